// File: rtl/hazard_flush_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_flush_ctrl_if : pipeline-status inputs and flush/freeze outputs of
//                        the hazard/flush controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hazard_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_use_src2;
  logic [3:0]       exe_dst;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dst;
  logic             mem_wb_en;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;
  logic             freeze_if;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             stall_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src2,
    input  exe_dst, exe_wb_en, exe_mem_r_en,
    input  mem_dst, mem_wb_en, mem_req, mem_ready, branch_taken,
    output freeze_if, flush_if_id, flush_id_ex, stall_all,
    output mem_timeout, stall_cycles
  );

  modport master (
    output id_valid, id_src1, id_src2, id_use_src2,
    output exe_dst, exe_wb_en, exe_mem_r_en,
    output mem_dst, mem_wb_en, mem_req, mem_ready, branch_taken,
    input  freeze_if, flush_if_id, flush_id_ex, stall_all,
    input  mem_timeout, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_flush_ctrl : RAW/branch/memory-wait flush and freeze controller.
//                     Optional macro FORWARDING_EN restricts stalls to load-use.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_flush_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  wire                      clk,
  input  wire                      rst,
  hazard_flush_ctrl_if.slave       bus
);

  localparam int WCNT_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WCNT_W   = (WCNT_RAW < 1) ? 1 : WCNT_RAW;
  localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_timeout_set;
  logic              w_freeze_if, w_flush_if_id, w_flush_id_ex, w_stall_all;
  logic              w_raw_exe, w_raw_mem, w_hazard;

  assign w_raw_exe = bus.id_valid & bus.exe_wb_en &
                     ((bus.id_src1 == bus.exe_dst) |
                      (bus.id_use_src2 & (bus.id_src2 == bus.exe_dst)));
  assign w_raw_mem = bus.id_valid & bus.mem_wb_en &
                     ((bus.id_src1 == bus.mem_dst) |
                      (bus.id_use_src2 & (bus.id_src2 == bus.mem_dst)));

`ifdef FORWARDING_EN
  assign w_hazard = w_raw_exe & bus.exe_mem_r_en;
`else
  assign w_hazard = w_raw_exe | w_raw_mem;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;
    w_freeze_if   = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_stall_all   = 1'b0;

    case (r_state)
      S_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          w_stall_all = 1'b1;
          w_state_nxt = S_WAIT;
          w_wait_nxt  = WCNT_W'(1);
        end else if (bus.branch_taken) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (w_hazard) begin
          w_freeze_if   = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      S_WAIT: begin
        // Release resolves branch/hazard in the same cycle, no extra bubble
        if (bus.mem_ready) begin
          w_state_nxt = S_RUN;
          if (bus.branch_taken) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
          end else if (w_hazard) begin
            w_freeze_if   = 1'b1;
            w_flush_id_ex = 1'b1;
          end
        end else begin
          w_stall_all = 1'b1;
          if ((MEM_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_VAL)) begin
            w_state_nxt   = S_HALT;
            w_timeout_set = 1'b1;
          end else if (r_wait_cnt != '1) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end
        end
      end
      S_HALT: begin
        w_stall_all = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (rst) begin
      w_freeze_if   = 1'b0;
      w_flush_if_id = 1'b0;
      w_flush_id_ex = 1'b0;
      w_stall_all   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (w_state_nxt == S_RUN) ? '0 : w_wait_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if ((w_freeze_if | w_stall_all) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.freeze_if    = w_freeze_if;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.flush_id_ex  = w_flush_id_ex;
  assign bus.stall_all    = w_stall_all;
  assign bus.mem_timeout  = r_timeout;
  assign bus.stall_cycles = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_flush_ctrl : directed self-checking bench for hazard_flush_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_flush_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  int         n_cmp;
  int         n_err;
  logic [3:0] exp_cnt;

  hazard_flush_ctrl_if #(.CNT_W(4)) bus ();

  hazard_flush_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    bus.id_valid     = 1'b0;
    bus.id_src1      = 4'd0;
    bus.id_src2      = 4'd0;
    bus.id_use_src2  = 1'b0;
    bus.exe_dst      = 4'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_r_en = 1'b0;
    bus.mem_dst      = 4'd0;
    bus.mem_wb_en    = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already applied; checks combinational
  // controls, advances one clock, then checks the registered outputs.
  task automatic step(input string tag, input logic fz, input logic fif,
                      input logic fie, input logic sa, input logic mt);
    #1;
    chk({tag, ".freeze_if"},   {3'b0, bus.freeze_if},   {3'b0, fz});
    chk({tag, ".flush_if_id"}, {3'b0, bus.flush_if_id}, {3'b0, fif});
    chk({tag, ".flush_id_ex"}, {3'b0, bus.flush_id_ex}, {3'b0, fie});
    chk({tag, ".stall_all"},   {3'b0, bus.stall_all},   {3'b0, sa});
    if (rst) exp_cnt = 4'd0;
    else if ((fz | sa) && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
    chk({tag, ".stall_cycles"}, bus.stall_cycles, exp_cnt);
    chk({tag, ".mem_timeout"},  {3'b0, bus.mem_timeout}, {3'b0, mt});
    @(negedge clk);
  endtask

  task automatic raw_exe(input logic [3:0] r);
    bus.id_valid  = 1'b1;
    bus.id_src1   = r;
    bus.exe_dst   = r;
    bus.exe_wb_en = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 4'd0;
    rst     = 1'b1;
    bus.id_valid = 1'b1; bus.id_src1 = 4'hF; bus.id_src2 = 4'hF; bus.id_use_src2 = 1'b1;
    bus.exe_dst = 4'hF; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
    bus.mem_dst = 4'hF; bus.mem_wb_en = 1'b1; bus.mem_req = 1'b1;
    bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    @(negedge clk);
    step("rst0", 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0);
    rst = 1'b0;
    clr();
    step("idle", 0, 0, 0, 0, 0);

    // ALU producer in EXE, then MEM, then gone
    raw_exe(4'd1);
    step("raw_exe", !FWD, 0, !FWD, 0, 0);
    bus.exe_wb_en = 1'b0; bus.mem_dst = 4'd1; bus.mem_wb_en = 1'b1;
    step("raw_mem", !FWD, 0, !FWD, 0, 0);
    bus.mem_wb_en = 1'b0;
    step("raw_done", 0, 0, 0, 0, 0);

    // Load-use: always one bubble, second only without forwarding
    clr(); raw_exe(4'd7); bus.exe_mem_r_en = 1'b1;
    step("load_exe", 1, 0, 1, 0, 0);
    bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.mem_dst = 4'd7; bus.mem_wb_en = 1'b1;
    step("load_mem", !FWD, 0, !FWD, 0, 0);

    // src2 only counts when used; R0 is ordinary; invalid ID never hazards
    clr(); bus.id_valid = 1'b1; bus.id_src1 = 4'd2; bus.id_src2 = 4'd5;
    bus.exe_dst = 4'd5; bus.exe_wb_en = 1'b1;
    step("src2_unused", 0, 0, 0, 0, 0);
    bus.id_use_src2 = 1'b1;
    step("src2_used", !FWD, 0, !FWD, 0, 0);
    clr(); raw_exe(4'd0); bus.exe_mem_r_en = 1'b1;
    step("reg0", 1, 0, 1, 0, 0);
    bus.id_valid = 1'b0;
    step("id_invalid", 0, 0, 0, 0, 0);

    // Branch beats a simultaneous hazard, single cycle
    clr(); raw_exe(4'd3); bus.exe_mem_r_en = 1'b1; bus.branch_taken = 1'b1;
    step("br_haz", 0, 1, 1, 0, 0);
    clr();
    step("br_after", 0, 0, 0, 0, 0);

    // Memory wait 3 cycles, branch ignored while stalled, taken on release
    raw_exe(4'd3); bus.exe_mem_r_en = 1'b1; bus.branch_taken = 1'b1;
    bus.mem_req = 1'b1;
    step("memA0", 0, 0, 0, 1, 0);
    step("memA1", 0, 0, 0, 1, 0);
    step("memA2", 0, 0, 0, 1, 0);
    bus.mem_ready = 1'b1;
    step("memA_rdy", 0, 1, 1, 0, 0);
    clr();
    step("memA_after", 0, 0, 0, 0, 0);

    // Four not-ready cycles is the last count before timeout
    bus.mem_req = 1'b1;
    step("memB0", 0, 0, 0, 1, 0);
    step("memB1", 0, 0, 0, 1, 0);
    step("memB2", 0, 0, 0, 1, 0);
    step("memB3", 0, 0, 0, 1, 0);
    raw_exe(4'd9); bus.exe_mem_r_en = 1'b1; bus.mem_ready = 1'b1;
    step("memB_rdy", 1, 0, 1, 0, 0);
    clr();
    step("memB_after", 0, 0, 0, 0, 0);

    // Timeout into HALT; inputs ignored; counter saturates
    bus.mem_req = 1'b1;
    step("to0", 0, 0, 0, 1, 0);
    step("to1", 0, 0, 0, 1, 0);
    step("to2", 0, 0, 0, 1, 0);
    step("to3", 0, 0, 0, 1, 0);
    step("to4", 0, 0, 0, 1, 1);
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    raw_exe(4'd4);
    step("halt0", 0, 0, 0, 1, 1);
    step("halt1", 0, 0, 0, 1, 1);
    step("halt2", 0, 0, 0, 1, 1);
    chk("sat_reached", {3'b0, exp_cnt == 4'hF}, 4'd1);

    rst = 1'b1;
    step("rst_halt", 0, 0, 0, 0, 0);
    rst = 1'b0;
    clr();
    step("post_rst", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
